round_checker: RTL



---
 rtl/game_pkg.sv | 33 +++
 rtl/bin2bcd_seq.sv | 72 +++++++
 rtl/round_checker.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared types and constants for the number-guessing game blocks.
// Level limits here are the defaults used by the generator, checker and display.
package game_pkg;

    localparam int NUM_W                 = 10;
    localparam int LEVEL_W               = 4;
    localparam int BCD_DIGITS            = 3;
    localparam int BCD_W                 = 4 * BCD_DIGITS;
    localparam int MAX_LEVEL_DEF         = 10;
    localparam int SIGNED_FROM_LEVEL_DEF = 7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_SETTLE,
        ST_CONV,
        ST_WAIT,
        ST_RESULT
    } state_e;

    // Double-dabble correction: any digit that will reach 10+ after the shift gets +3 first.
    function automatic logic [BCD_W-1:0] dabble_adj(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        r = b;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (b[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = b[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble: one bit per clock, first bit folded into the start cycle,
// so the three digits are ready with a one-cycle done pulse 10 clocks after start.
module bin2bcd_seq
    import game_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [NUM_W-1:0] mag,
    output logic             busy,
    output logic             done,
    output logic [3:0]       bcd_h,
    output logic [3:0]       bcd_t,
    output logic [3:0]       bcd_o
);

    logic [BCD_W-1:0]       bcd_q, bcd_d;
    logic [NUM_W-1:0]       sh_q, sh_d;
    logic [3:0]             cnt_q, cnt_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [BCD_W+NUM_W-1:0] step_in, step_out;

    always_comb begin
        bcd_d   = bcd_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        step_in = {bcd_q, sh_q};
        if (start && !busy_q) begin
            step_in = {{BCD_W{1'b0}}, mag};
        end
        step_out = {dabble_adj(step_in[BCD_W+NUM_W-1:NUM_W]), step_in[NUM_W-1:0]} << 1;

        if (start && !busy_q) begin
            {bcd_d, sh_d} = step_out;
            cnt_d         = 4'd1;
            busy_d        = 1'b1;
        end else if (busy_q) begin
            {bcd_d, sh_d} = step_out;
            cnt_d         = cnt_q + 4'd1;
            if (cnt_q == 4'(NUM_W - 1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bcd_q  <= '0;
            sh_q   <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            bcd_q  <= bcd_d;
            sh_q   <= sh_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign bcd_h = bcd_q[11:8];
    assign bcd_t = bcd_q[7:4];
    assign bcd_o = bcd_q[3:0];

endmodule

// File: rtl/round_checker.sv
// Game-round controller: fetches a target from the generator, shows it as sign + BCD,
// judges the player's answer and tracks streak and level.
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   ST_IDLE   | after reset, waiting for start
//   ST_REQ    | num_gen pulse, clear display/result flags
//   ST_SETTLE | wait for generator output, capture target and magnitude
//   ST_CONV   | binary-to-BCD conversion running
//   ST_WAIT   | digits shown, waiting for a submit edge
//   ST_RESULT | correct/wrong held, start begins the next round
module round_checker
    import game_pkg::*;
#(
    parameter int SETTLE_CYCLES     = 2,
    parameter int STREAK_TO_LEVEL   = 3,
    parameter int MAX_LEVEL         = MAX_LEVEL_DEF,
    parameter int SIGNED_FROM_LEVEL = SIGNED_FROM_LEVEL_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               submit,
    input  logic [NUM_W-1:0]   answer,
    input  logic [NUM_W-1:0]   number,
    output logic [LEVEL_W-1:0] level,
    output logic               num_gen,
    output logic               busy,
    output logic               neg,
    output logic [3:0]         bcd_h,
    output logic [3:0]         bcd_t,
    output logic [3:0]         bcd_o,
    output logic               disp_valid,
    output logic               correct,
    output logic               wrong,
    output logic [1:0]         streak
);

    localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);

    state_e               state_q, state_d;
    logic [SETTLE_W-1:0]  settle_cnt_q, settle_cnt_d;
    logic [LEVEL_W-1:0]   level_q, level_d;
    logic [NUM_W-1:0]     tgt_q, tgt_d;
    logic                 neg_q, neg_d;
    logic [3:0]           bcd_h_q, bcd_h_d, bcd_t_q, bcd_t_d, bcd_o_q, bcd_o_d;
    logic                 disp_valid_q, disp_valid_d;
    logic                 correct_q, correct_d;
    logic                 wrong_q, wrong_d;
    logic [1:0]           streak_q, streak_d;
    logic                 num_gen_q, num_gen_d;
    logic                 busy_q, busy_d;
    logic                 sync1_q, sync2_q, sub_prev_q;

    logic                 sub_pulse, signed_mode, num_neg, settle_last;
    logic [NUM_W-1:0]     mag;
    logic                 conv_start, conv_busy, conv_done;
    logic [3:0]           conv_h, conv_t, conv_o;

    assign sub_pulse   = sync2_q & ~sub_prev_q;
    assign signed_mode = (level_q >= LEVEL_W'(SIGNED_FROM_LEVEL));
    assign num_neg     = signed_mode & number[NUM_W-1];
    // 0x200 negates to itself, which reads correctly as an unsigned magnitude of 512.
    assign mag         = num_neg ? (~number + NUM_W'(1)) : number;
    assign settle_last = (settle_cnt_q == SETTLE_W'(SETTLE_CYCLES - 1));

    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .reset (reset),
        .start (conv_start),
        .mag   (mag),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd_h (conv_h),
        .bcd_t (conv_t),
        .bcd_o (conv_o)
    );

    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        level_d      = level_q;
        tgt_d        = tgt_q;
        neg_d        = neg_q;
        bcd_h_d      = bcd_h_q;
        bcd_t_d      = bcd_t_q;
        bcd_o_d      = bcd_o_q;
        disp_valid_d = disp_valid_q;
        correct_d    = correct_q;
        wrong_d      = wrong_q;
        streak_d     = streak_q;
        conv_start   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_REQ;
            end
            ST_REQ: begin
                settle_cnt_d = '0;
                state_d      = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (!settle_last) begin
                    settle_cnt_d = settle_cnt_q + SETTLE_W'(1);
                end else if (!conv_busy) begin
                    tgt_d      = number;
                    neg_d      = num_neg;
                    conv_start = 1'b1;
                    state_d    = ST_CONV;
                end
            end
            ST_CONV: begin
                if (conv_done) begin
                    bcd_h_d      = conv_h;
                    bcd_t_d      = conv_t;
                    bcd_o_d      = conv_o;
                    disp_valid_d = 1'b1;
                    state_d      = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (sub_pulse) begin
                    state_d = ST_RESULT;
                    if (answer == tgt_q) begin
                        correct_d = 1'b1;
                        if (streak_q == 2'(STREAK_TO_LEVEL - 1)) begin
                            streak_d = '0;
                            if (level_q < LEVEL_W'(MAX_LEVEL)) level_d = level_q + LEVEL_W'(1);
                        end else begin
                            streak_d = streak_q + 2'd1;
                        end
                    end else begin
                        wrong_d  = 1'b1;
                        streak_d = '0;
                    end
                end
            end
            ST_RESULT: begin
                if (start) state_d = ST_REQ;
            end
            default: state_d = ST_IDLE;
        endcase

        // Flags clear on the same edge num_gen rises, so they are already low during REQ.
        if (state_d == ST_REQ) begin
            disp_valid_d = 1'b0;
            correct_d    = 1'b0;
            wrong_d      = 1'b0;
        end
        num_gen_d = (state_d == ST_REQ);
        busy_d    = (state_d == ST_REQ) || (state_d == ST_SETTLE) || (state_d == ST_CONV);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            settle_cnt_q <= '0;
            level_q      <= LEVEL_W'(1);
            tgt_q        <= '0;
            neg_q        <= 1'b0;
            bcd_h_q      <= '0;
            bcd_t_q      <= '0;
            bcd_o_q      <= '0;
            disp_valid_q <= 1'b0;
            correct_q    <= 1'b0;
            wrong_q      <= 1'b0;
            streak_q     <= '0;
            num_gen_q    <= 1'b0;
            busy_q       <= 1'b0;
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            sub_prev_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            level_q      <= level_d;
            tgt_q        <= tgt_d;
            neg_q        <= neg_d;
            bcd_h_q      <= bcd_h_d;
            bcd_t_q      <= bcd_t_d;
            bcd_o_q      <= bcd_o_d;
            disp_valid_q <= disp_valid_d;
            correct_q    <= correct_d;
            wrong_q      <= wrong_d;
            streak_q     <= streak_d;
            num_gen_q    <= num_gen_d;
            busy_q       <= busy_d;
            sync1_q      <= submit;
            sync2_q      <= sync1_q;
            sub_prev_q   <= sync2_q;
        end
    end

    assign level      = level_q;
    assign num_gen    = num_gen_q;
    assign busy       = busy_q;
    assign neg        = neg_q;
    assign bcd_h      = bcd_h_q;
    assign bcd_t      = bcd_t_q;
    assign bcd_o      = bcd_o_q;
    assign disp_valid = disp_valid_q;
    assign correct    = correct_q;
    assign wrong      = wrong_q;
    assign streak     = streak_q;

endmodule
